ora_comp_ctrl: RTL and testbench

//  Sequencer for the comparator-based ORA (#2). On start, steps the pattern source through NPAT patterns.
//  Per pattern: settle, then compare CUT response against golden response via the comp XNOR comparator.

---
 rtl/ora_comp_ctrl_pkg.sv | 24 ++
 rtl/ora_comp_ctrl_if.sv | 32 +++
 rtl/ora_comp_ctrl_comp.sv | 12 +
 rtl/ora_comp_ctrl.sv | 129 ++++++++++++
 tb/tb_ora_comp_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/ora_comp_ctrl_pkg.sv
// Shared definitions for the comparator-based ORA sequencer: state encoding and
// counter width helper.
package ora_comp_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_APPLY = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CMP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    APPLY = ST_APPLY,
    WAIT  = ST_WAIT,
    CMP   = ST_CMP,
    DONE  = ST_DONE
  } state_t;

  // Bits needed to hold the values 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ora_comp_ctrl_if.sv
// Handshake/result bundle between the LBIST controller and the ORA sequencer.
// ORA_FIRST_FAIL_EN adds the first-failure capture signals.
interface ora_comp_ctrl_if #(
  parameter int BITS  = 2,
  parameter int CNT_W = 5
);
  logic              start;
  logic [0:BITS-1]   cut_out;
  logic [0:BITS-1]   gold_out;
  logic              pat_en;
  logic [CNT_W-1:0]  pat_idx;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  fail_cnt;
`ifdef ORA_FIRST_FAIL_EN
  logic              first_fail_vld;
  logic [CNT_W-1:0]  first_fail_idx;

  modport slave  (input  start, cut_out, gold_out,
                  output pat_en, pat_idx, busy, done, pass, fail_cnt,
                         first_fail_vld, first_fail_idx);
  modport master (output start, cut_out, gold_out,
                  input  pat_en, pat_idx, busy, done, pass, fail_cnt,
                         first_fail_vld, first_fail_idx);
`else
  modport slave  (input  start, cut_out, gold_out,
                  output pat_en, pat_idx, busy, done, pass, fail_cnt);
  modport master (output start, cut_out, gold_out,
                  input  pat_en, pat_idx, busy, done, pass, fail_cnt);
`endif
endinterface

// File: rtl/ora_comp_ctrl_comp.sv
// XNOR response comparator: res=1 when any bit of the CUT word differs from golden.
module comp #(
  parameter int BITS = 2
) (
  input  logic [0:BITS-1] a,
  input  logic [0:BITS-1] b,
  output logic            res
);

  assign res = ~&(a ~^ b);

endmodule

// File: rtl/ora_comp_ctrl.sv
// Comparator-ORA sequencer: steps NPAT patterns, settles, compares, counts mismatches.
// Optional first-failure capture when ORA_FIRST_FAIL_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// APPLY | pat_en strobe, advance pattern source
// WAIT  | SETTLE cycles for CUT response to settle
// CMP   | sample comparator, count mismatch, next pattern or finish
// DONE  | result valid, waiting for start
module ora_comp_ctrl
  import ora_comp_ctrl_pkg::*;
#(
  parameter int BITS   = 2,
  parameter int NPAT   = 16,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 5
) (
  input logic            clk,
  input logic            rst,
  ora_comp_ctrl_if.slave bus
);

  localparam int               WAIT_W      = cnt_width(SETTLE);
  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(NPAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD  = WAIT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam state_t           AFTER_APPLY = (SETTLE > 0) ? WAIT : CMP;

  state_t             state;
  state_t             state_nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]   pat_idx;
  logic [CNT_W-1:0]   fail_cnt;
  logic               res;
  logic               sess_clr;
  logic               idx_inc;
  logic               fail_inc;

  comp #(.BITS(BITS)) u_comp (
    .a   (bus.cut_out),
    .b   (bus.gold_out),
    .res (res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sess_clr  = 1'b0;
    idx_inc   = 1'b0;
    fail_inc  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt = APPLY;
          sess_clr  = 1'b1;
        end
      end
      APPLY: state_nxt = AFTER_APPLY;
      WAIT: begin
        if (wait_cnt == '0) state_nxt = CMP;
      end
      CMP: begin
        fail_inc = res;
        if (pat_idx == LAST_IDX) begin
          state_nxt = DONE;
        end else begin
          idx_inc   = 1'b1;
          state_nxt = APPLY;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ORA_FIRST_FAIL_EN
  logic             ff_vld;
  logic [CNT_W-1:0] ff_idx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_idx  <= '0;
      fail_cnt <= '0;
      wait_cnt <= '0;
`ifdef ORA_FIRST_FAIL_EN
      ff_vld   <= 1'b0;
      ff_idx   <= '0;
`endif
    end else begin
      if (sess_clr) begin
        pat_idx  <= '0;
        fail_cnt <= '0;
`ifdef ORA_FIRST_FAIL_EN
        ff_vld   <= 1'b0;
        ff_idx   <= '0;
`endif
      end else begin
        if (idx_inc) pat_idx <= pat_idx + 1'b1;
        if (fail_inc && fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
`ifdef ORA_FIRST_FAIL_EN
        // only the earliest mismatch of a session is kept
        if (fail_inc && !ff_vld) begin
          ff_vld <= 1'b1;
          ff_idx <= pat_idx;
        end
`endif
      end
      if (state == APPLY)                        wait_cnt <= WAIT_LOAD;
      else if (state == WAIT && wait_cnt != '0)  wait_cnt <= wait_cnt - 1'b1;
    end
  end

  // Outputs decode the state register directly, so reset clears them at once.
  assign bus.pat_en   = (state == APPLY);
  assign bus.busy     = (state == APPLY) || (state == WAIT) || (state == CMP);
  assign bus.done     = (state == DONE);
  assign bus.pass     = (state == DONE) && (fail_cnt == '0);
  assign bus.pat_idx  = pat_idx;
  assign bus.fail_cnt = fail_cnt;
`ifdef ORA_FIRST_FAIL_EN
  assign bus.first_fail_vld = ff_vld;
  assign bus.first_fail_idx = ff_idx;
`endif

endmodule

// File: tb/tb_ora_comp_ctrl.sv
// Self-checking bench for ora_comp_ctrl: session table with a result scoreboard,
// plus hand sequences for reset abort and the SETTLE=0 / NPAT=1 build.
module tb_ora_comp_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ora_comp_ctrl_if #(.BITS(2), .CNT_W(5)) if1 ();
  ora_comp_ctrl_if #(.BITS(2), .CNT_W(1)) if2 ();

  ora_comp_ctrl #(.BITS(2), .NPAT(16), .SETTLE(1), .CNT_W(5)) u_dut1 (
    .clk (clk), .rst (rst), .bus (if1.slave));
  ora_comp_ctrl #(.BITS(2), .NPAT(1), .SETTLE(0), .CNT_W(1)) u_dut2 (
    .clk (clk), .rst (rst), .bus (if2.slave));

  typedef struct {
    logic [15:0] mask;
    bit          outside;
    bit          busy_start;
    int          exp_fail;
    bit          exp_pass;
  } vec_t;

  typedef struct {
    int fail;
    bit pass;
    int ff_idx;
    bit ff_vld;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Monitor: pat_en spacing/index and end-of-session results against the scoreboard.
  int pulses = 0;
  int first_cyc = 0;
  int last_pe = 0;
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    if (if1.pat_en) begin
      if (if1.pat_idx == 5'd0) begin
        pulses    = 1;
        first_cyc = cyc;
      end else begin
        chk("pe_gap", cyc - last_pe, 3);
        chk("pe_idx", {27'd0, if1.pat_idx}, pulses);
        pulses++;
      end
      last_pe = cyc;
    end
    if (if1.done && !prev_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("fail_cnt", {27'd0, if1.fail_cnt}, e.fail);
        chk("pass", {31'd0, if1.pass}, {31'd0, e.pass});
        chk("pulses", pulses, 16);
        chk("done_lat", cyc - first_cyc, 48);
`ifdef ORA_FIRST_FAIL_EN
        chk("ff_vld", {31'd0, if1.first_fail_vld}, {31'd0, e.ff_vld});
        if (e.ff_vld) chk("ff_idx", {27'd0, if1.first_fail_idx}, e.ff_idx);
`endif
      end
    end
    prev_done = if1.done;
  end

  task automatic drive1(bit mism);
    if1.cut_out  = 2'b01;
    if1.gold_out = mism ? 2'b10 : 2'b01;
  endtask

  task automatic run_session(vec_t v);
    exp_t e;
    e.fail   = v.exp_fail;
    e.pass   = v.exp_pass;
    e.ff_vld = (v.mask != 16'd0);
    e.ff_idx = 0;
    for (int i = 15; i >= 0; i--) if (v.mask[i]) e.ff_idx = i;
    sb.push_back(e);
    @(negedge clk);
    if1.start = 1'b1;
    drive1(1'b0);
    @(negedge clk);
    if1.start = 1'b0;
    chk("start_done_clr", {31'd0, if1.done}, 0);
    chk("start_busy", {31'd0, if1.busy}, 1);
    for (int p = 0; p < 16; p++) begin
      drive1(v.outside);
      @(negedge clk);
      drive1(v.outside);
      if (v.busy_start && p == 5) if1.start = 1'b1;
      @(negedge clk);
      if1.start = 1'b0;
      drive1(v.mask[p]);
      @(negedge clk);
    end
    drive1(1'b0);
    for (int k = 0; k < 5 && sb.size() != 0; k++) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("done_held", {31'd0, if1.done}, 1);
  endtask

  initial begin
    int c0;
    vecs[0] = '{16'h0000, 1'b0, 1'b0, 0, 1'b1};
    vecs[1] = '{16'h8088, 1'b0, 1'b0, 3, 1'b0};
    vecs[2] = '{16'hFFFF, 1'b0, 1'b0, 16, 1'b0};
    vecs[3] = '{16'h0000, 1'b0, 1'b1, 0, 1'b1};
    vecs[4] = '{16'h0000, 1'b1, 1'b0, 0, 1'b1};
    vecs[5] = '{16'h0001, 1'b1, 1'b1, 1, 1'b0};

    if1.start = 1'b0;
    if2.start = 1'b0;
    drive1(1'b0);
    if2.cut_out  = 2'b01;
    if2.gold_out = 2'b10;

    repeat (2) @(negedge clk);
    chk("rst_pat_en", {31'd0, if1.pat_en}, 0);
    chk("rst_busy", {31'd0, if1.busy}, 0);
    chk("rst_done", {31'd0, if1.done}, 0);
    chk("rst_pass", {31'd0, if1.pass}, 0);
    chk("rst_fail_cnt", {27'd0, if1.fail_cnt}, 0);
    chk("rst_pat_idx", {27'd0, if1.pat_idx}, 0);
    rst = 1'b0;

    // Reset asserted in the middle of WAIT aborts the session.
    @(negedge clk);
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    chk("abort_apply_pe", {31'd0, if1.pat_en}, 1);
    @(negedge clk);
    chk("abort_wait_busy", {31'd0, if1.busy}, 1);
    chk("abort_wait_pe", {31'd0, if1.pat_en}, 0);
    rst = 1'b1;
    #1;
    chk("abort_async_busy", {31'd0, if1.busy}, 0);
    @(negedge clk);
    chk("abort_busy", {31'd0, if1.busy}, 0);
    chk("abort_pat_en", {31'd0, if1.pat_en}, 0);
    chk("abort_done", {31'd0, if1.done}, 0);
    chk("abort_pass", {31'd0, if1.pass}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", {30'd0, if1.busy, if1.pat_en}, 0);
    chk("abort_idx", {27'd0, if1.pat_idx}, 0);

    for (int i = 0; i < 6; i++) run_session(vecs[i]);

    // SETTLE=0, NPAT=1, CNT_W=1 with constant mismatch, two sessions back to back.
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      if2.start = 1'b1;
      @(negedge clk);
      if2.start = 1'b0;
      c0 = cyc;
      chk("n1_apply_pe", {31'd0, if2.pat_en}, 1);
      chk("n1_apply_done", {31'd0, if2.done}, 0);
      @(negedge clk);
      chk("n1_cmp_pe", {31'd0, if2.pat_en}, 0);
      chk("n1_cmp_busy", {31'd0, if2.busy}, 1);
      @(negedge clk);
      chk("n1_done", {31'd0, if2.done}, 1);
      chk("n1_lat", cyc - c0, 2);
      chk("n1_fail_cnt", {31'd0, if2.fail_cnt}, 1);
      chk("n1_pass", {31'd0, if2.pass}, 0);
`ifdef ORA_FIRST_FAIL_EN
      chk("n1_ff_vld", {31'd0, if2.first_fail_vld}, 1);
      chk("n1_ff_idx", {31'd0, if2.first_fail_idx}, 0);
`endif
      repeat (2) @(negedge clk);
      chk("n1_sat_hold", {31'd0, if2.fail_cnt}, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
